alsu_pipe: RTL

ALSU_PIPE -- requirements
Module: alsu_pipe

---
 rtl/alsu_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alsu_pipe.sv
// Two-stage pipelined arithmetic/logic/shift unit: stage 1 captures the operation, stage 2 computes it.
// Optional LED blink pattern on error is enabled by defining ALSU_LED_BLINK_EN.
module alsu_pipe #(
   parameter int WIDTH          = 8,
   parameter int INPUT_PRIORITY = 1,
   parameter int FULL_ADDER     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [2:0]           opcode,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 direction,
   input  logic                 red_op_a,
   input  logic                 red_op_b,
   input  logic                 bypass_a,
   input  logic                 bypass_b,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic                 error,
   output logic [15:0]          leds
);

   localparam int OUT_W  = 2 * WIDTH;
   localparam bit PRIO_A = (INPUT_PRIORITY != 0);
   localparam bit USE_CIN = (FULL_ADDER != 0);

   logic             s1_valid_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [2:0]       opcode_r;
   logic             cin_r;
   logic             serial_in_r;
   logic             direction_r;
   logic             red_a_r;
   logic             red_b_r;
   logic             byp_a_r;
   logic             byp_b_r;

   logic [WIDTH:0]   sum_s;
   logic [OUT_W-1:0] prod_s;
   logic [WIDTH-1:0] prev_s;
   logic [WIDTH-1:0] shift_s;
   logic [WIDTH-1:0] rot_s;
   logic             pick_a_byp_s;
   logic             pick_a_red_s;
   logic             invalid_s;
   logic [OUT_W-1:0] result_s;
   logic             err_s;

   // Stage 1: capture the operation when offered; the valid bit always follows in_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         opcode_r    <= 3'd0;
         cin_r       <= 1'b0;
         serial_in_r <= 1'b0;
         direction_r <= 1'b0;
         red_a_r     <= 1'b0;
         red_b_r     <= 1'b0;
         byp_a_r     <= 1'b0;
         byp_b_r     <= 1'b0;
      end else begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            a_r         <= a;
            b_r         <= b;
            opcode_r    <= opcode;
            cin_r       <= cin;
            serial_in_r <= serial_in;
            direction_r <= direction;
            red_a_r     <= red_op_a;
            red_b_r     <= red_op_b;
            byp_a_r     <= bypass_a;
            byp_b_r     <= bypass_b;
         end
      end
   end

   assign sum_s  = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, (cin_r & USE_CIN)};
   assign prod_s = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};

   // Shifts and rotates chain off the result currently held in the output register.
   assign prev_s  = out[WIDTH-1:0];
   assign shift_s = direction_r ? {prev_s[WIDTH-2:0], serial_in_r} : {serial_in_r, prev_s[WIDTH-1:1]};
   assign rot_s   = direction_r ? {prev_s[WIDTH-2:0], prev_s[WIDTH-1]} : {prev_s[0], prev_s[WIDTH-1:1]};

   assign pick_a_byp_s = byp_a_r & (~byp_b_r | PRIO_A);
   assign pick_a_red_s = red_a_r & (~red_b_r | PRIO_A);
   assign invalid_s    = (opcode_r[2] & opcode_r[1]) | ((red_a_r | red_b_r) & (opcode_r >= 3'd2));

   // Stage 2 result selection: bypass, then invalid check, then opcode.
   always_comb begin
      result_s = {OUT_W{1'b0}};
      err_s    = 1'b0;
      if (byp_a_r | byp_b_r) begin
         result_s = {{WIDTH{1'b0}}, (pick_a_byp_s ? a_r : b_r)};
      end else if (invalid_s) begin
         err_s = 1'b1;
      end else begin
         case (opcode_r)
            3'd0: begin
               if (red_a_r | red_b_r) begin
                  result_s = {{(OUT_W-1){1'b0}}, (pick_a_red_s ? (&a_r) : (&b_r))};
               end else begin
                  result_s = {{WIDTH{1'b0}}, (a_r & b_r)};
               end
            end
            3'd1: begin
               if (red_a_r | red_b_r) begin
                  result_s = {{(OUT_W-1){1'b0}}, (pick_a_red_s ? (^a_r) : (^b_r))};
               end else begin
                  result_s = {{WIDTH{1'b0}}, (a_r ^ b_r)};
               end
            end
            3'd2:    result_s = {{(WIDTH-1){1'b0}}, sum_s};
            3'd3:    result_s = prod_s;
            3'd4:    result_s = {{WIDTH{1'b0}}, shift_s};
            3'd5:    result_s = {{WIDTH{1'b0}}, rot_s};
            default: err_s    = 1'b1;
         endcase
      end
   end

   // Stage 2: register the result; out and error hold when no operation completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= {OUT_W{1'b0}};
         out_valid <= 1'b0;
         error     <= 1'b0;
      end else begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            out   <= result_s;
            error <= err_s;
         end
      end
   end

`ifdef ALSU_LED_BLINK_EN
   logic err_next_s;
   assign err_next_s = s1_valid_r ? err_s : error;

   // LED pattern: all on as error rises, then toggles every cycle while error stays set.
   always_ff @(posedge clk) begin
      if (rst) begin
         leds <= 16'h0000;
      end else if (!err_next_s) begin
         leds <= 16'h0000;
      end else if (!error) begin
         leds <= 16'hFFFF;
      end else begin
         leds <= ~leds;
      end
   end
`else
   assign leds = 16'h0000;
`endif

endmodule
